// File: rtl/pe_pkg.sv
// Shared definitions for the pe_mac_seq processing element: FSM state encoding
// and default datapath widths.
package pe_pkg;

  localparam int PE_PIXEL_WIDTH = 16;
  localparam int PE_PSUM_WIDTH  = 32;
  localparam int PE_LEN_WIDTH   = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEED  = 3'd1,
    ST_MAC   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4
  } pe_state_e;

endpackage

// File: rtl/pe_mac_seq_if.sv
// Job, operand, multiplier and result signals of pe_mac_seq.
// sat_flag exists only when PE_MAC_SAT_EN is defined.
interface pe_mac_seq_if
  import pe_pkg::*;
#(
  parameter int PIXEL_WIDTH = PE_PIXEL_WIDTH,
  parameter int PSUM_WIDTH  = PE_PSUM_WIDTH,
  parameter int LEN_WIDTH   = PE_LEN_WIDTH
) ();

  logic                           start;
  logic [LEN_WIDTH-1:0]           cfg_len;
  logic                           psum_in_valid;
  logic                           psum_in_ready;
  logic signed [PSUM_WIDTH-1:0]   psum_in;
  logic                           op_valid;
  logic                           op_ready;
  logic signed [PIXEL_WIDTH-1:0]  op_ifmap;
  logic signed [PIXEL_WIDTH-1:0]  op_weight;
  logic                           mul_en;
  logic signed [PIXEL_WIDTH-1:0]  mul_a;
  logic signed [PIXEL_WIDTH-1:0]  mul_b;
  logic signed [2*PIXEL_WIDTH-1:0] mul_product;
  logic                           psum_out_valid;
  logic                           psum_out_ready;
  logic signed [PSUM_WIDTH-1:0]   psum_out;
  logic                           busy;
`ifdef PE_MAC_SAT_EN
  logic                           sat_flag;
`endif

  modport master (
    output start, cfg_len, psum_in_valid, psum_in, op_valid, op_ifmap, op_weight,
           mul_product, psum_out_ready,
`ifdef PE_MAC_SAT_EN
    input  sat_flag,
`endif
    input  psum_in_ready, op_ready, mul_en, mul_a, mul_b, psum_out_valid, psum_out, busy
  );

  modport slave (
    input  start, cfg_len, psum_in_valid, psum_in, op_valid, op_ifmap, op_weight,
           mul_product, psum_out_ready,
`ifdef PE_MAC_SAT_EN
    output sat_flag,
`endif
    output psum_in_ready, op_ready, mul_en, mul_a, mul_b, psum_out_valid, psum_out, busy
  );

endinterface

// File: rtl/pe_psum_acc.sv
// Psum accumulator: seed load plus add of the sign-extended product. Wraps by default;
// with PE_MAC_SAT_EN defined it saturates and keeps a sticky sat_flag.
module pe_psum_acc #(
  parameter int PSUM_WIDTH = 32,
  parameter int PROD_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_en,
  input  logic signed [PSUM_WIDTH-1:0] load_val,
  input  logic                         add_en,
  input  logic signed [PROD_WIDTH-1:0] addend,
`ifdef PE_MAC_SAT_EN
  input  logic                         clear_flag,
  output logic                         sat_flag,
`endif
  output logic signed [PSUM_WIDTH-1:0] acc
);

  logic signed [PSUM_WIDTH-1:0] acc_d;
  logic signed [PSUM_WIDTH-1:0] acc_q;
  logic signed [PSUM_WIDTH-1:0] addend_ext;
  logic signed [PSUM_WIDTH-1:0] sum;

  assign addend_ext = PSUM_WIDTH'(addend);
  assign sum        = acc_q + addend_ext;

`ifdef PE_MAC_SAT_EN
  localparam logic signed [PSUM_WIDTH-1:0] ACC_MAX = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
  localparam logic signed [PSUM_WIDTH-1:0] ACC_MIN = {1'b1, {(PSUM_WIDTH-1){1'b0}}};

  logic sat_d;
  logic sat_q;
  logic ovf_pos;
  logic ovf_neg;

  // Overflow only when both operands share a sign and the sum flips it.
  assign ovf_pos = !acc_q[PSUM_WIDTH-1] && !addend_ext[PSUM_WIDTH-1] && sum[PSUM_WIDTH-1];
  assign ovf_neg = acc_q[PSUM_WIDTH-1] && addend_ext[PSUM_WIDTH-1] && !sum[PSUM_WIDTH-1];

  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    if (clear_flag) begin
      sat_d = 1'b0;
    end else begin
      sat_d = sat_q;
    end
    if (load_en) begin
      acc_d = load_val;
    end else if (add_en) begin
      if (ovf_pos) begin
        acc_d = ACC_MAX;
        sat_d = 1'b1;
      end else if (ovf_neg) begin
        acc_d = ACC_MIN;
        sat_d = 1'b1;
      end else begin
        acc_d = sum;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  assign sat_flag = sat_q;
`else
  always_comb begin
    acc_d = acc_q;
    if (load_en) begin
      acc_d = load_val;
    end else if (add_en) begin
      acc_d = sum;
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`endif

  assign acc = acc_q;

endmodule

// File: rtl/pe_mac_seq.sv
// Sequential psum MAC element: seed, N MACs through an external 1-cycle multiplier,
// one flush cycle, then drain. Define PE_MAC_SAT_EN for saturating accumulation.
module pe_mac_seq
  import pe_pkg::*;
#(
  parameter int PIXEL_WIDTH = PE_PIXEL_WIDTH,
  parameter int PSUM_WIDTH  = PE_PSUM_WIDTH,
  parameter int LEN_WIDTH   = PE_LEN_WIDTH
) (
  input logic         clk,
  input logic         reset,
  pe_mac_seq_if.slave bus
);

  pe_state_e                    state_d;
  pe_state_e                    state_q;
  logic [LEN_WIDTH-1:0]         count_d;
  logic [LEN_WIDTH-1:0]         count_q;
  logic                         issue_d;
  logic                         issue_q;
  logic                         start_fire;
  logic                         seed_fire;
  logic                         op_fire;
  logic signed [PSUM_WIDTH-1:0] acc;

  assign start_fire = (state_q == ST_IDLE) && bus.start;
  assign seed_fire  = (state_q == ST_SEED) && bus.psum_in_valid;
  assign op_fire    = (state_q == ST_MAC) && bus.op_valid;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    issue_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          count_d = bus.cfg_len;
          state_d = ST_SEED;
        end
      end
      ST_SEED: begin
        if (bus.psum_in_valid) begin
          state_d = (count_q == '0) ? ST_FLUSH : ST_MAC;
        end
      end
      ST_MAC: begin
        if (bus.op_valid) begin
          issue_d = 1'b1;
          count_d = count_q - LEN_WIDTH'(1);
          if (count_q == LEN_WIDTH'(1)) begin
            state_d = ST_FLUSH;
          end
        end
      end
      // The last product arrives at the edge closing this cycle.
      ST_FLUSH: state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (bus.psum_out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      issue_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      issue_q <= issue_d;
    end
  end

  assign bus.psum_in_ready  = (state_q == ST_SEED);
  assign bus.op_ready       = (state_q == ST_MAC);
  assign bus.mul_en         = op_fire;
  assign bus.mul_a          = op_fire ? bus.op_ifmap  : '0;
  assign bus.mul_b          = op_fire ? bus.op_weight : '0;
  assign bus.psum_out_valid = (state_q == ST_DRAIN);
  assign bus.psum_out       = acc;
  assign bus.busy           = (state_q != ST_IDLE);

  pe_psum_acc #(
    .PSUM_WIDTH (PSUM_WIDTH),
    .PROD_WIDTH (2*PIXEL_WIDTH)
  ) u_acc (
    .clk        (clk),
    .reset      (reset),
    .load_en    (seed_fire),
    .load_val   (bus.psum_in),
    .add_en     (issue_q),
    .addend     (bus.mul_product),
`ifdef PE_MAC_SAT_EN
    .clear_flag (start_fire),
    .sat_flag   (bus.sat_flag),
`endif
    .acc        (acc)
  );

endmodule

// File: tb/tb_pe_mac_seq.sv
// Bench for pe_mac_seq: randomized jobs checked every cycle against a behavioural psum
// model, plus directed literal cases. Honours PE_MAC_SAT_EN when defined.
module tb_pe_mac_seq;

  localparam int PW = 16;
  localparam int SW = 32;
  localparam int LW = 4;
  localparam longint SMAX = (longint'(1) <<< (SW-1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (SW-1));

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  pe_mac_seq_if #(.PIXEL_WIDTH(PW), .PSUM_WIDTH(SW), .LEN_WIDTH(LW)) bus ();

  pe_mac_seq #(.PIXEL_WIDTH(PW), .PSUM_WIDTH(SW), .LEN_WIDTH(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // External multiplier: operands registered on the rising edge, product on the falling edge.
  logic signed [PW-1:0] ma_q;
  logic signed [PW-1:0] mb_q;
  always @(posedge clk) begin
    ma_q <= bus.mul_a;
    mb_q <= bus.mul_b;
    cyc  <= cyc + 1;
  end
  always @(negedge clk) bus.mul_product <= (2*PW)'(ma_q) * (2*PW)'(mb_q);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_ps(input string name, input logic signed [SW-1:0] act,
                        input logic signed [SW-1:0] exp);
    chk(name, {32'd0, act}, {32'd0, exp});
  endtask

  // Behavioural model: job phase, remaining operand count, psum value
  int ph = 0;
  int rem = 0;
  int mul_cnt = 0;
  logic signed [SW-1:0] m_acc = '0;
  logic m_sat = 1'b0;

  task automatic model_mac(input logic signed [PW-1:0] a, input logic signed [PW-1:0] b);
    longint s;
    s = longint'(m_acc) + longint'(a) * longint'(b);
`ifdef PE_MAC_SAT_EN
    if (s > SMAX) begin
      s = SMAX;
      m_sat = 1'b1;
    end else if (s < SMIN) begin
      s = SMIN;
      m_sat = 1'b1;
    end
`endif
    m_acc = SW'(s);
  endtask

  always @(negedge clk) begin
    logic [PW-1:0] ea;
    logic [PW-1:0] eb;
    if (reset) begin
      chk("rst_busy", {63'd0, bus.busy}, 64'd0);
      chk("rst_psum_in_ready", {63'd0, bus.psum_in_ready}, 64'd0);
      chk("rst_op_ready", {63'd0, bus.op_ready}, 64'd0);
      chk("rst_mul_en", {63'd0, bus.mul_en}, 64'd0);
      chk("rst_mul_a", {48'd0, bus.mul_a}, 64'd0);
      chk("rst_mul_b", {48'd0, bus.mul_b}, 64'd0);
      chk("rst_psum_out_valid", {63'd0, bus.psum_out_valid}, 64'd0);
      chk("rst_psum_out", {32'd0, bus.psum_out}, 64'd0);
      ph = 0;
      rem = 0;
      m_acc = '0;
      m_sat = 1'b0;
    end else begin
      ea = (ph == 2 && bus.op_valid) ? bus.op_ifmap : 16'd0;
      eb = (ph == 2 && bus.op_valid) ? bus.op_weight : 16'd0;
      chk("busy", {63'd0, bus.busy}, {63'd0, ph != 0});
      chk("psum_in_ready", {63'd0, bus.psum_in_ready}, {63'd0, ph == 1});
      chk("op_ready", {63'd0, bus.op_ready}, {63'd0, ph == 2});
      chk("mul_en", {63'd0, bus.mul_en}, {63'd0, ph == 2 && bus.op_valid});
      chk("mul_a", {48'd0, bus.mul_a}, {48'd0, ea});
      chk("mul_b", {48'd0, bus.mul_b}, {48'd0, eb});
      chk("psum_out_valid", {63'd0, bus.psum_out_valid}, {63'd0, ph == 4});
      if (ph == 4) begin
        chk_ps("psum_out", bus.psum_out, m_acc);
`ifdef PE_MAC_SAT_EN
        chk("sat_flag", {63'd0, bus.sat_flag}, {63'd0, m_sat});
`endif
      end
      case (ph)
        0: if (bus.start) begin
          rem = int'(bus.cfg_len);
          m_sat = 1'b0;
          ph = 1;
        end
        1: if (bus.psum_in_valid) begin
          m_acc = bus.psum_in;
          ph = (rem == 0) ? 3 : 2;
        end
        2: if (bus.op_valid) begin
          model_mac(bus.op_ifmap, bus.op_weight);
          mul_cnt++;
          rem--;
          if (rem == 0) ph = 3;
        end
        3: ph = 4;
        4: if (bus.psum_out_ready) ph = 0;
        default: ph = 0;
      endcase
    end
  end

  logic signed [PW-1:0] ifm [16];
  logic signed [PW-1:0] wgt [16];
  int gap [16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sig(input string name, ref logic sig);
    int t;
    t = 0;
    while (!sig && t < 50) begin
      step();
      t++;
    end
    if (t >= 50) begin
      failures++;
      checks++;
      $display("FAIL %s timeout actual=0 required=1", name);
    end
  endtask

  task automatic do_job(input int len, input logic signed [SW-1:0] seed, input int hold,
                        input bit poke, output logic signed [SW-1:0] res, output int lat);
    int t0;
    mul_cnt = 0;
    bus.start = 1'b1;
    bus.cfg_len = LW'(len);
    step();
    bus.start = 1'b0;
    bus.cfg_len = LW'($urandom);
    bus.psum_in_valid = 1'b1;
    bus.psum_in = seed;
    wait_sig("seed_wait", bus.psum_in_ready);
    step();
    bus.psum_in_valid = 1'b0;
    bus.psum_in = SW'($urandom);
    t0 = cyc;
    for (int i = 0; i < len; i++) begin
      for (int g = 0; g < gap[i]; g++) begin
        bus.op_valid = 1'b0;
        bus.op_ifmap = PW'($urandom);
        bus.op_weight = PW'($urandom);
        step();
      end
      bus.op_valid = 1'b1;
      bus.op_ifmap = ifm[i];
      bus.op_weight = wgt[i];
      wait_sig("op_wait", bus.op_ready);
      if (i == 0) t0 = cyc;
      step();
    end
    bus.op_valid = 1'b0;
    wait_sig("drain_wait", bus.psum_out_valid);
    lat = cyc - t0;
    res = bus.psum_out;
    for (int h = 0; h < hold; h++) begin
      bus.start = poke && (h == 1 || h == 3);
      chk_ps("drain_hold_stable", bus.psum_out, res);
      chk("drain_hold_busy", {63'd0, bus.busy}, 64'd1);
      step();
    end
    bus.start = 1'b0;
    bus.psum_out_ready = 1'b1;
    step();
    bus.psum_out_ready = 1'b0;
    chk("idle_after_drain", {63'd0, bus.busy}, 64'd0);
  endtask

  initial begin
    logic signed [SW-1:0] res;
    int lat;
    int len;
    bit nogap;
    bus.start = 1'b0;
    bus.cfg_len = '0;
    bus.psum_in_valid = 1'b0;
    bus.psum_in = '0;
    bus.op_valid = 1'b0;
    bus.op_ifmap = '0;
    bus.op_weight = '0;
    bus.psum_out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();

    // len 3 back-to-back: 10 + 6 - 20 - 7
    ifm[0] = 16'sd2;  wgt[0] = 16'sd3;  gap[0] = 0;
    ifm[1] = -16'sd4; wgt[1] = 16'sd5;  gap[1] = 0;
    ifm[2] = 16'sd7;  wgt[2] = -16'sd1; gap[2] = 0;
    do_job(3, 32'sd10, 0, 1'b0, res, lat);
    chk_ps("lit_len3_psum", res, -32'sd11);
    chk("lit_len3_latency", 64'(lat), 64'd4);
    chk("lit_len3_mul_cnt", 64'(mul_cnt), 64'd3);

    // len 2 with a 2-cycle operand gap
    ifm[0] = -16'sd128; wgt[0] = -16'sd128; gap[0] = 0;
    ifm[1] = 16'sd1;    wgt[1] = 16'sd1;    gap[1] = 2;
    do_job(2, 32'sd0, 0, 1'b0, res, lat);
    chk_ps("lit_gap_psum", res, 32'sd16385);
    chk("lit_gap_mul_cnt", 64'(mul_cnt), 64'd2);

    // len 0: seed passes straight through
    do_job(0, -32'sd42, 0, 1'b0, res, lat);
    chk_ps("lit_len0_psum", res, -32'sd42);
    chk("lit_len0_mul_cnt", 64'(mul_cnt), 64'd0);

    // positive overflow
    ifm[0] = 16'sd16; wgt[0] = 16'sd16; gap[0] = 0;
    do_job(1, 32'sh7FFFFFF0, 0, 1'b0, res, lat);
`ifdef PE_MAC_SAT_EN
    chk_ps("lit_ovf_sat_psum", res, 32'sh7FFFFFFF);
    chk("lit_ovf_sat_flag", {63'd0, bus.sat_flag}, 64'd1);
`else
    chk_ps("lit_ovf_wrap_psum", res, 32'sh800000F0);
`endif

    // drain back-pressure with start pulses
    ifm[0] = 16'sd3; wgt[0] = 16'sd4; gap[0] = 0;
    do_job(1, 32'sd1, 5, 1'b1, res, lat);
    chk_ps("lit_hold_psum", res, 32'sd13);

    // reset after 1 of 3 operands, then a fresh job
    bus.start = 1'b1;
    bus.cfg_len = 4'd3;
    step();
    bus.start = 1'b0;
    bus.psum_in_valid = 1'b1;
    bus.psum_in = 32'sd7;
    step();
    bus.psum_in_valid = 1'b0;
    bus.op_valid = 1'b1;
    bus.op_ifmap = 16'sd9;
    bus.op_weight = 16'sd9;
    step();
    reset = 1'b1;
    bus.op_valid = 1'b0;
    #1;
    chk("lit_midrst_busy", {63'd0, bus.busy}, 64'd0);
    chk("lit_midrst_psum_out", {32'd0, bus.psum_out}, 64'd0);
    chk("lit_midrst_op_ready", {63'd0, bus.op_ready}, 64'd0);
    step();
    reset = 1'b0;
    step();
    ifm[0] = 16'sd5; wgt[0] = 16'sd5; gap[0] = 0;
    do_job(1, 32'sd0, 0, 1'b0, res, lat);
    chk_ps("lit_after_rst_psum", res, 32'sd25);

    // randomized jobs
    for (int j = 0; j < 40; j++) begin
      len = $urandom_range(0, 15);
      nogap = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < 16; i++) begin
        ifm[i] = PW'($urandom);
        wgt[i] = PW'($urandom);
        gap[i] = nogap ? 0 : $urandom_range(0, 2);
      end
      if (j % 4 == 0) begin
        do_job(len, 32'sh7FFF0000 + SW'($urandom_range(0, 65535)), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), res, lat);
      end else begin
        do_job(len, SW'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)), res, lat);
      end
      if (nogap && len > 0) chk("b2b_latency", 64'(lat), 64'(len + 1));
      chk("rand_mul_cnt", 64'(mul_cnt), 64'(len));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_mac_seq.md
PE_MAC_SEQ -- requirements
Module: pe_mac_seq

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 16, operand width of the shared signed multiplier.
REQ-002 SHALL have parameter PSUM_WIDTH, default 32, accumulator and psum width; PSUM_WIDTH >= 2*PIXEL_WIDTH.
REQ-003 SHALL have parameter LEN_WIDTH, default 4, width of the MAC count.
REQ-004 clk  input  1  rising-edge clock; the multiplier internally uses the falling edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  pulse; begins one psum job in IDLE; ignored otherwise.
REQ-007 cfg_len  input  LEN_WIDTH  number of MACs per job, latched at start.
REQ-008 psum_in_valid / psum_in_ready  input / output  1 each  seed psum handshake.
REQ-009 psum_in  input  PSUM_WIDTH  signed seed psum.
REQ-010 op_valid / op_ready  input / output  1 each  operand pair handshake.
REQ-011 op_ifmap, op_weight  input  PIXEL_WIDTH each  signed operands.
REQ-012 mul_en  output  1  drives multiplier enable.
REQ-013 mul_a, mul_b  output  PIXEL_WIDTH each  multiplier operands.
REQ-014 mul_product  input  2*PIXEL_WIDTH  signed multiplier result.
REQ-015 psum_out_valid / psum_out_ready  output / input  1 each  result handshake.
REQ-016 psum_out  output  PSUM_WIDTH  signed result psum.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 SHALL implement FSM IDLE -> SEED -> MAC -> FLUSH -> DRAIN -> IDLE.
REQ-019 IDLE: start=1 -> latch cfg_len into count register, go SEED.
REQ-020 SEED: psum_in_ready=1; on psum_in_valid load accumulator with psum_in, go MAC (FLUSH if latched len=0).
REQ-021 MAC: op_ready=1; each op_valid&op_ready cycle -> mul_en=1, mul_a=op_ifmap, mul_b=op_weight, decrement count; op_valid=0 -> mul_en=0, no decrement (stall).
REQ-022 Multiplier latency: product for operands issued in cycle k is sampled at the rising edge ending cycle k+1 (1-cycle pipeline, registered issue flag).
REQ-023 Accumulator adds sign-extended mul_product only at edges whose issue flag is set; stalled cycles add nothing.
REQ-024 Last operand accepted -> go FLUSH; FLUSH lasts exactly one cycle for the final product, then DRAIN.
REQ-025 DRAIN: psum_out_valid=1, psum_out=accumulator held stable; on psum_out_ready go IDLE.
REQ-026 start in any non-IDLE state SHALL be ignored; cfg_len changes after start SHALL not affect the job.
REQ-027 Back-to-back: job of len N with op_valid constant 1 SHALL take N+1 cycles from first operand to DRAIN.
REQ-028 Accumulation SHALL wrap modulo 2^PSUM_WIDTH unless REQ-033 applies.
REQ-029 mul_a/mul_b SHALL be 0 whenever mul_en=0.

Reset
REQ-030 reset SHALL force IDLE, accumulator=0, count=0, issue flag=0, all ready/valid/mul_en outputs=0, psum_out=0, busy=0.
REQ-031 reset mid-job SHALL abandon the job; the in-flight product SHALL not be accumulated after release.

Configuration
REQ-032 Macro PE_MAC_SAT_EN SHALL select accumulator overflow behaviour.
REQ-033 With PE_MAC_SAT_EN: accumulator saturates to the signed PSUM_WIDTH max/min and a sticky sat_flag output (1 bit, cleared at start and reset) is provided; without it: wrap-around, no sat_flag port.

Structure
REQ-034 Shared package pe_pkg SHALL hold the FSM state enum, default PIXEL_WIDTH/PSUM_WIDTH constants.
REQ-035 One sub-module pe_psum_acc (accumulator register, add, optional saturation) is natural; the multiplier stays external.

Verification
REQ-036 len=3, seed=10, pairs (2,3),(-4,5),(7,-1), op_valid steady -> psum_out=10+6-20-7=-11, DRAIN 4 cycles after first operand.
REQ-037 len=2, pairs (-128,-128),(1,1) with 2 idle op_valid cycles between -> mul_en low in gaps, psum_out=16385 with seed 0.
REQ-038 len=0, seed=-42 -> no mul_en pulse, psum_out=-42.
REQ-039 Seed 0x7FFFFFF0, pair (16,16): without macro psum_out=0x800000F0; with PE_MAC_SAT_EN psum_out=0x7FFFFFFF, sat_flag=1.
REQ-040 reset asserted during MAC after 1 of 3 operands -> all outputs 0 next cycle; new start job len=1, seed 0, (5,5) -> psum_out=25.
REQ-041 psum_out_ready held 0 for 5 cycles, start pulsed meanwhile -> psum_out stable, start ignored, busy=1.
